// File: rtl/fetch_unit_pkg.sv
// Shared state encoding, opcodes and PC step for the instruction fetch stage.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      ERR   = 2'd2
   } fetch_state_t;

   localparam logic [5:0]  OP_J    = 6'b000010;
   localparam logic [5:0]  OP_BEQ  = 6'b000100;
   localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ack bus and core-side valid/ready bus of the fetch stage.
interface fetch_unit_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        core_ready;
   logic        branch_en;
   logic        alu_zero;
   logic        jump_en;

   modport master (
      output imem_req, imem_addr, instr, instr_pc, instr_valid,
      input  imem_ack, imem_rdata, core_ready, branch_en, alu_zero, jump_en
   );

   modport slave (
      input  imem_req, imem_addr, instr, instr_pc, instr_valid,
      output imem_ack, imem_rdata, core_ready, branch_en, alu_zero, jump_en
   );

endinterface

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: sequential, taken branch or jump (jump has priority).
module fetch_unit_next_pc_calc
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] STEP = PC_STEP
) (
   input  logic [31:0] instr,
   input  logic [31:0] instr_pc,
   input  logic        branch_en,
   input  logic        alu_zero,
   input  logic        jump_en,
   output logic [31:0] next_pc
);

   logic [31:0]        pc4;
   logic signed [31:0] br_off;

   // Word offset of a branch, converted to a signed byte offset.
   function automatic logic signed [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

   always_comb begin
      pc4     = instr_pc + STEP;
      br_off  = branch_offset(instr[15:0]);
      next_pc = pc4;
      if (jump_en) begin
         next_pc = {pc4[31:28], instr[25:0], 2'b00};
      end else if (branch_en && alu_zero) begin
         next_pc = pc4 + $unsigned(br_off);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, fetches over req/ack, holds the word for the core under
// valid/ready, and latches a sticky error if memory never acknowledges.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter logic [31:0] PC_STEP    = fetch_unit_pkg::PC_STEP,
   parameter logic [3:0]  TIMEOUT    = 4'd15
) (
   input  logic          clk,
   input  logic          clr_n,
   fetch_unit_if.master  bus,
   output logic          fetch_err
);

   fetch_state_t state, state_nxt;
   logic [3:0]   wait_cnt, wait_nxt;
   logic [31:0]  pc, next_pc;
   logic [31:0]  instr_r, instr_pc_r;
   logic         load_instr, accept;

   fetch_unit_next_pc_calc #(
      .STEP(PC_STEP)
   ) u_next_pc (
      .instr    (instr_r),
      .instr_pc (instr_pc_r),
      .branch_en(bus.branch_en),
      .alu_zero (bus.alu_zero),
      .jump_en  (bus.jump_en),
      .next_pc  (next_pc)
   );

   always_comb begin
      state_nxt  = state;
      wait_nxt   = wait_cnt;
      load_instr = 1'b0;
      accept     = 1'b0;
      case (state)
         FETCH: begin
            // An ack arriving on the final allowed cycle still wins over the timeout.
            if (bus.imem_ack) begin
               state_nxt  = HOLD;
               load_instr = 1'b1;
            end else if (wait_cnt == TIMEOUT) begin
               state_nxt = ERR;
            end else begin
               wait_nxt = wait_cnt + 4'd1;
            end
         end
         HOLD: begin
            if (bus.core_ready) begin
               state_nxt = FETCH;
               accept    = 1'b1;
               wait_nxt  = 4'd0;
            end
         end
         default: state_nxt = ERR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state    <= FETCH;
         wait_cnt <= 4'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         pc         <= RESET_ADDR;
         instr_r    <= 32'd0;
         instr_pc_r <= 32'd0;
      end else begin
         if (load_instr) begin
            instr_r    <= bus.imem_rdata;
            instr_pc_r <= pc;
         end
         if (accept) begin
            pc <= next_pc;
         end
      end
   end

   assign bus.imem_req    = (state == FETCH);
   assign bus.imem_addr   = pc;
   assign bus.instr       = instr_r;
   assign bus.instr_pc    = instr_pc_r;
   assign bus.instr_valid = (state == HOLD);
   assign fetch_err       = (state == ERR);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: redirect vector table, hand-written timing corners and a random
// fetch/accept stream checked against an arithmetic next-PC model.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic clk = 1'b0;
   logic clr_n;
   logic fetch_err;

   fetch_unit_if bus();

   fetch_unit dut (
      .clk      (clk),
      .clr_n    (clr_n),
      .bus      (bus),
      .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
      logic        jmp;
      logic        br;
      logic        zero;
      logic [31:0] nxt;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'hDEAD_BEEF;
      bus.core_ready = 1'b0;
      bus.branch_en  = 1'b0;
      bus.alu_zero   = 1'b0;
      bus.jump_en    = 1'b0;
   endtask

   task automatic do_reset();
      clr_n = 1'b0;
      step();
      clr_n = 1'b1;
   endtask

   // Memory answers on the lat-th FETCH cycle; request and address must be steady until then.
   task automatic mem_fetch(input logic [31:0] word, input int lat,
                            input logic [31:0] exp_addr, input string tag);
      for (int i = 0; i < lat; i++) begin
         chk({tag, " req"}, 32'(bus.imem_req), 32'd1);
         chk({tag, " addr"}, bus.imem_addr, exp_addr);
         if (i == lat - 1) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = word;
         end
         step();
      end
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = $urandom;
      chk({tag, " valid"}, 32'(bus.instr_valid), 32'd1);
      chk({tag, " instr"}, bus.instr, word);
      chk({tag, " instr_pc"}, bus.instr_pc, exp_addr);
   endtask

   // Core stalls, with junk on the redirect lines, then accepts with the given controls.
   task automatic core_accept(input logic [31:0] word, input logic [31:0] ipc, input int stall,
                              input logic j, input logic b, input logic z, input string tag);
      for (int i = 0; i < stall; i++) begin
         bus.core_ready = 1'b0;
         bus.jump_en    = 1'($urandom_range(0, 1));
         bus.branch_en  = 1'($urandom_range(0, 1));
         bus.alu_zero   = 1'($urandom_range(0, 1));
         step();
         chk({tag, " stall valid"}, 32'(bus.instr_valid), 32'd1);
         chk({tag, " stall req"}, 32'(bus.imem_req), 32'd0);
         chk({tag, " stall instr"}, bus.instr, word);
         chk({tag, " stall instr_pc"}, bus.instr_pc, ipc);
      end
      bus.core_ready = 1'b1;
      bus.jump_en    = j;
      bus.branch_en  = b;
      bus.alu_zero   = z;
      step();
      idle_inputs();
   endtask

   function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w,
                                              input logic j, input logic b, input logic z);
      logic [31:0] seq;
      int          off;
      seq = pc + 32'd4;
      if (j) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 32'd4);
      off = $signed(w[15:0]);
      if (b && z) return seq + 32'(off * 4);
      return seq;
   endfunction

   // Steer the PC from reset to target (regions 0x0 and 0xF only).
   task automatic goto_pc(input logic [31:0] target);
      logic [31:0] jw;
      logic [31:0] bw;
      jw = {OP_J, target[27:2]};
      bw = {OP_BEQ, 10'd0, 16'h8000};
      do_reset();
      if (target[31:28] == 4'h0) begin
         mem_fetch(jw, 1, 32'h0, "goto j");
         core_accept(jw, 32'h0, 0, 1'b1, 1'b0, 1'b0, "goto j");
      end else begin
         mem_fetch(bw, 1, 32'h0, "goto b");
         core_accept(bw, 32'h0, 0, 1'b0, 1'b1, 1'b1, "goto b");
         mem_fetch(jw, 1, 32'hFFFE_0004, "goto j");
         core_accept(jw, 32'hFFFE_0004, 0, 1'b1, 1'b0, 1'b0, "goto j");
      end
      chk("goto addr", bus.imem_addr, target);
   endtask

   initial begin
      #500_000;
      $display("FAIL global timeout: bench did not finish, got no end expected end");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{32'h0000_0010, 32'h1022_FFFE, 1'b0, 1'b1, 1'b1, 32'h0000_000C};
      tbl[1] = '{32'h0000_0010, 32'h1022_FFFE, 1'b0, 1'b1, 1'b0, 32'h0000_0014};
      tbl[2] = '{32'hF000_0000, 32'h0800_0040, 1'b1, 1'b1, 1'b1, 32'hF000_0100};
      tbl[3] = '{32'h0000_0100, 32'h1000_0010, 1'b0, 1'b1, 1'b1, 32'h0000_0144};
      tbl[4] = '{32'h0000_0200, 32'h1000_0010, 1'b0, 1'b0, 1'b1, 32'h0000_0204};
      tbl[5] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
      tbl[6] = '{32'hFFFF_FFFC, 32'h1000_0004, 1'b0, 1'b1, 1'b1, 32'h0000_0010};
      tbl[7] = '{32'h0FFF_FFFC, 32'h0800_0123, 1'b1, 1'b0, 1'b0, 32'h1000_048C};
      tbl[8] = '{32'h0000_0040, 32'h1000_8000, 1'b0, 1'b1, 1'b1, 32'hFFFE_0044};

      idle_inputs();
      do_reset();
      chk("reset req", 32'(bus.imem_req), 32'd1);
      chk("reset addr", bus.imem_addr, 32'h0);
      chk("reset valid", 32'(bus.instr_valid), 32'd0);
      chk("reset err", 32'(fetch_err), 32'd0);
      chk("reset instr", bus.instr, 32'h0);
      chk("reset instr_pc", bus.instr_pc, 32'h0);

      // Registered memory (acks one cycle after seeing req), core always ready.
      begin : tput
         logic prev;
         prev = 1'b0;
         do_reset();
         bus.core_ready = 1'b1;
         for (int c = 0; c < 9; c++) begin
            chk("tput valid", 32'(bus.instr_valid), 32'(c % 3 == 2));
            if (bus.imem_req && !prev) chk("tput addr", bus.imem_addr, 32'(c / 3 * 4));
            bus.imem_ack   = bus.imem_req && prev;
            bus.imem_rdata = 32'(c);
            prev           = bus.imem_req && !bus.imem_ack;
            step();
         end
         idle_inputs();
      end

      // Slow memory and a stalling core.
      do_reset();
      mem_fetch(32'hCAFE_0001, 5, 32'h0, "lat5");
      core_accept(32'hCAFE_0001, 32'h0, 4, 1'b0, 1'b0, 1'b0, "stall4");
      chk("after stall req", 32'(bus.imem_req), 32'd1);
      chk("after stall addr", bus.imem_addr, 32'h4);

      // Watchdog expires after 16 unacknowledged FETCH cycles and stays there.
      do_reset();
      for (int c = 0; c < 16; c++) begin
         chk("wd req", 32'(bus.imem_req), 32'd1);
         chk("wd err early", 32'(fetch_err), 32'd0);
         step();
      end
      chk("wd err", 32'(fetch_err), 32'd1);
      chk("wd req off", 32'(bus.imem_req), 32'd0);
      chk("wd valid off", 32'(bus.instr_valid), 32'd0);
      bus.imem_ack   = 1'b1;
      bus.core_ready = 1'b1;
      for (int c = 0; c < 3; c++) step();
      idle_inputs();
      chk("wd sticky err", 32'(fetch_err), 32'd1);
      chk("wd sticky req", 32'(bus.imem_req), 32'd0);

      // Ack on the 16th cycle beats the timeout.
      do_reset();
      mem_fetch(32'h1234_5678, 16, 32'h0, "wd16");
      chk("wd16 no err", 32'(fetch_err), 32'd0);
      core_accept(32'h1234_5678, 32'h0, 1, 1'b0, 1'b0, 1'b0, "wd16");
      chk("wd16 next addr", bus.imem_addr, 32'h4);

      // Reset during HOLD while the core is accepting a jump.
      do_reset();
      mem_fetch(32'h0800_0100, 1, 32'h0, "rsthold");
      bus.core_ready = 1'b1;
      bus.jump_en    = 1'b1;
      do_reset();
      idle_inputs();
      chk("rsthold valid", 32'(bus.instr_valid), 32'd0);
      chk("rsthold err", 32'(fetch_err), 32'd0);
      chk("rsthold req", 32'(bus.imem_req), 32'd1);
      chk("rsthold addr", bus.imem_addr, 32'h0);
      chk("rsthold instr", bus.instr, 32'h0);

      // Reset with an ack pending in FETCH: the ack is dropped.
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'h5555_AAAA;
      do_reset();
      bus.imem_ack = 1'b0;
      chk("rstack valid", 32'(bus.instr_valid), 32'd0);
      chk("rstack req", 32'(bus.imem_req), 32'd1);
      chk("rstack instr", bus.instr, 32'h0);

      for (int v = 0; v < 9; v++) begin
         goto_pc(tbl[v].pc);
         mem_fetch(tbl[v].word, 1, tbl[v].pc, "tbl");
         core_accept(tbl[v].word, tbl[v].pc, v % 3, tbl[v].jmp, tbl[v].br, tbl[v].zero, "tbl");
         chk($sformatf("tbl[%0d] next addr", v), bus.imem_addr, tbl[v].nxt);
      end

      // Random traffic, occasionally starving the unit into the error state.
      begin : rnd
         logic [31:0] mpc;
         logic [31:0] w;
         logic        j, b, z;
         int          lat;
         do_reset();
         mpc = 32'h0;
         for (int t = 0; t < 60; t++) begin
            lat = ($urandom_range(0, 9) == 0) ? 17 : int'($urandom_range(1, 16));
            if (lat > 16) begin
               chk("rnd to addr", bus.imem_addr, mpc);
               for (int c = 0; c < 16; c++) step();
               chk("rnd to err", 32'(fetch_err), 32'd1);
               chk("rnd to req", 32'(bus.imem_req), 32'd0);
               do_reset();
               mpc = 32'h0;
            end else begin
               w = $urandom;
               j = ($urandom_range(0, 3) == 0);
               b = 1'($urandom_range(0, 1));
               z = 1'($urandom_range(0, 1));
               mem_fetch(w, lat, mpc, "rnd");
               core_accept(w, mpc, int'($urandom_range(0, 3)), j, b, z, "rnd");
               mpc = model_next(mpc, w, j, b, z);
               chk("rnd next addr", bus.imem_addr, mpc);
               chk("rnd err", 32'(fetch_err), 32'd0);
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
